cam_config_sequencer: RTL

CAM_CONFIG_SEQUENCER -- requirements
Module: cam_config_sequencer

---
 rtl/cam_config_sequencer_pkg.sv | 22 ++
 rtl/cam_config_sequencer_delay_timer.sv | 48 ++++
 rtl/cam_config_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cam_config_sequencer_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// State encoding, ROM word markers and camera indices.
package cam_config_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ROM_RD,
    DECODE,
    ISSUE,
    WAIT_DONE,
    DELAY,
    FINISH
  } state_t;

  localparam logic [15:0] END_MARKER = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG  = 8'hF0;

  localparam logic CAM1 = 1'b0;
  localparam logic CAM2 = 1'b1;

endpackage

// File: rtl/cam_config_sequencer_delay_timer.sv
// Delay counter: load nn, count nn*DELAY_UNIT cycles, then pulse expire (nn = 0 expires at once).
// Latency: expire is asserted in the last counted cycle; no backpressure.
module cfg_delay_timer #(
  parameter int DELAY_UNIT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] delay_ticks,
  output logic       expire
);

  localparam int CW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(DELAY_UNIT - 1);

  logic          active;
  logic [7:0]    remaining;
  logic [CW-1:0] cyc;
  logic          unit_end;

  assign unit_end = (cyc == CYC_LAST);
  // Fire in the final cycle of the last tick so the wait is exactly nn*DELAY_UNIT.
  assign expire   = active && ((remaining == 8'd0) || (remaining == 8'd1 && unit_end));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      remaining <= 8'd0;
      cyc       <= '0;
    end else if (load) begin
      active    <= 1'b1;
      remaining <= delay_ticks;
      cyc       <= '0;
    end else if (expire) begin
      active    <= 1'b0;
      remaining <= 8'd0;
      cyc       <= '0;
    end else if (active) begin
      if (unit_end) begin
        cyc       <= '0;
        remaining <= remaining - 8'd1;
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cam_config_sequencer.sv
// Walks the shared config ROM once per camera request, issuing SCCB writes with NACK retry and timed delays.
// Latency: request to first sccb_start is 5 cycles; stalls in ISSUE while sccb_busy and waits for sccb_done.
module cam_config_sequencer
  import cam_config_sequencer_pkg::*;
#(
  parameter int ROM_AW     = 8,
  parameter int DELAY_UNIT = 100000,
  parameter int RETRY_MAX  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_sel,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic [1:0]        cfg_done,
  output logic [1:0]        cfg_error,
  output logic              busy
);

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  state_t        state, state_nxt;
  logic [1:0]    pending;
  logic          rr_ptr;
  logic [RW-1:0] retry_cnt;
  logic          grant;
  logic          is_end;
  logic          is_delay;
  logic          retry_left;
  logic          timer_load;
  logic          timer_expire;

  assign grant      = pending[rr_ptr] ? rr_ptr : ~rr_ptr;
  // The last ROM word always ends the pass so rom_addr can never wrap.
  assign is_end     = (rom_data == END_MARKER) || (rom_addr == ADDR_LAST);
  assign is_delay   = (rom_data[15:8] == DELAY_TAG);
  assign retry_left = (retry_cnt < RW'(RETRY_MAX));
  assign timer_load = (state == DECODE) && !is_end && is_delay;

  cfg_delay_timer #(
    .DELAY_UNIT(DELAY_UNIT)
  ) u_delay_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .delay_ticks(rom_data[7:0]),
    .expire     (timer_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|pending) state_nxt = ARB;
      ARB:       state_nxt = ROM_RD;
      ROM_RD:    state_nxt = DECODE;
      DECODE: begin
        if (is_end)        state_nxt = FINISH;
        else if (is_delay) state_nxt = DELAY;
        else               state_nxt = ISSUE;
      end
      ISSUE:     if (!sccb_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (sccb_done) begin
          if (!sccb_nack)     state_nxt = ROM_RD;
          else if (retry_left) state_nxt = ISSUE;
          else                state_nxt = FINISH;
        end
      end
      DELAY:     if (timer_expire) state_nxt = ROM_RD;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    sccb_start = (state == ISSUE) && !sccb_busy;
  end

  // Power-up leaves both cameras pending so each gets configured once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= 2'b11;
      rr_ptr     <= CAM1;
      rom_addr   <= '0;
      sccb_sel   <= CAM1;
      sccb_reg   <= 8'd0;
      sccb_wdata <= 8'd0;
      cfg_done   <= 2'b00;
      cfg_error  <= 2'b00;
      retry_cnt  <= '0;
    end else begin
      pending <= pending | cfg_req;
      case (state)
        ARB: begin
          pending[grant]   <= cfg_req[grant];
          sccb_sel         <= grant;
          rom_addr         <= '0;
          cfg_done[grant]  <= 1'b0;
          cfg_error[grant] <= 1'b0;
          retry_cnt        <= '0;
        end
        DECODE: begin
          if (!is_end && !is_delay) {sccb_reg, sccb_wdata} <= rom_data;
        end
        WAIT_DONE: begin
          if (sccb_done) begin
            if (!sccb_nack) begin
              retry_cnt <= '0;
              rom_addr  <= rom_addr + ROM_AW'(1);
            end else if (retry_left) begin
              retry_cnt <= retry_cnt + RW'(1);
            end else begin
              cfg_error[sccb_sel] <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (timer_expire) rom_addr <= rom_addr + ROM_AW'(1);
        end
        FINISH: begin
          if (!cfg_error[sccb_sel]) cfg_done[sccb_sel] <= 1'b1;
          rr_ptr <= (sccb_sel == CAM1) ? CAM2 : CAM1;
        end
        default: ;
      endcase
    end
  end

endmodule
